// File: rtl/btn_debounce_repeat_pkg.sv
// rtl/btn_debounce_repeat_pkg.sv - shared state encoding and width helpers for the button conditioner
//
// Purpose: channel FSM state type plus constant functions used to size the
// prescaler, debounce and hold counters in the top and channel modules.
package btn_debounce_repeat_pkg;

  typedef enum logic [1:0] {
    ST_REL  = 2'd0,
    ST_HOLD = 2'd1,
    ST_REP  = 2'd2
  } chan_state_e;

  // Bits needed to count 0..n-1; never narrower than one bit so that a
  // threshold of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_repeat_chan.sv
// rtl/btn_debounce_repeat_chan.sv - one button channel: debounce counter, hold FSM, pulse registers
//
// Purpose: accepts a synchronised, polarity-corrected button level and the
// shared timing tick, and produces the debounced level plus registered
// press / release / long-press / auto-repeat pulses.
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous reset, active low
//   tick         one-clk timing strobe shared by all channels
//   s            synchronised level, 1 = pressed
//   btn_out      debounced level
//   btn_press    1-clk pulse on accepted press
//   btn_release  1-clk pulse on accepted release
//   btn_long     1-clk pulse once per press after LONG_TICKS
//   btn_rep      1-clk pulse at press, at long-press, then every REP_TICKS
module btn_debounce_repeat_chan
  import btn_debounce_repeat_pkg::*;
#(
  parameter int DB_TICKS   = 5,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  parameter bit REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic s,
  output logic btn_out,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_rep
);

  localparam int DB_W   = cnt_width(DB_TICKS);
  localparam int HOLD_W = cnt_width(max2(LONG_TICKS, REP_TICKS));

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_TICKS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_TICKS - 1);

  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              level_q, level_d;
  chan_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              rep_q, rep_d;

  logic accept;
  logic accept_press;
  logic accept_release;

  // Debounce: the counter only advances on ticks while the input disagrees
  // with the accepted level; any agreeing clock restarts the run.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    accept   = 1'b0;
    if (s == level_q) begin
      db_cnt_d = '0;
    end else if (tick) begin
      if (db_cnt_q == DB_LAST) begin
        accept   = 1'b1;
        level_d  = s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign accept_press   = accept & s;
  assign accept_release = accept & ~s;

  // Hold FSM. Pulses are computed from the same accept that updates the
  // level, so each pulse lands in the first cycle the new level is visible.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    rep_d      = 1'b0;
    if (accept_release) begin
      // Release takes priority over a long/repeat threshold on the same tick.
      state_d    = ST_REL;
      hold_cnt_d = '0;
      release_d  = 1'b1;
    end else begin
      case (state_q)
        ST_REL: begin
          if (accept_press) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            press_d    = 1'b1;
            rep_d      = 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hold_cnt_q == LONG_LAST) begin
              state_d    = ST_REP;
              hold_cnt_d = '0;
              long_d     = 1'b1;
              rep_d      = REP_EN;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        ST_REP: begin
          if (tick) begin
            if (hold_cnt_q == REP_LAST) begin
              hold_cnt_d = '0;
              rep_d      = REP_EN;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = ST_REL;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q   <= '0;
      level_q    <= 1'b0;
      state_q    <= ST_REL;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      rep_q      <= rep_d;
    end
  end

  assign btn_out     = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign btn_rep     = rep_q;

endmodule

// File: rtl/btn_debounce_repeat.sv
// rtl/btn_debounce_repeat.sv - multi-channel button debouncer with long-press and auto-repeat
//
// Purpose: synchronises raw key pins, corrects polarity, generates the shared
// timing tick and runs one independent conditioning channel per button.
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous reset, active low
//   btn_in       raw asynchronous button pins [BTN_WIDTH-1:0]
//   btn_out      debounced levels, 1 = pressed
//   btn_press    1-clk pulse per channel on accepted press
//   btn_release  1-clk pulse per channel on accepted release
//   btn_long     1-clk pulse per channel once per press at LONG_TICKS
//   btn_rep      1-clk pulse per channel at press, long-press, then every REP_TICKS
module btn_debounce_repeat
  import btn_debounce_repeat_pkg::*;
#(
  parameter int                   BTN_WIDTH  = 4,
  parameter int                   TICK_DIV   = 6000,
  parameter int                   DB_TICKS   = 5,
  parameter int                   LONG_TICKS = 1000,
  parameter int                   REP_TICKS  = 200,
  parameter logic [BTN_WIDTH-1:0] REP_EN     = {BTN_WIDTH{1'b1}},
  parameter bit                   ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [BTN_WIDTH-1:0] btn_out,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic [BTN_WIDTH-1:0] btn_long,
  output logic [BTN_WIDTH-1:0] btn_rep
);

  localparam int                   PRE_W     = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(TICK_DIV - 1);
  // Pin level of a released key; the sync chain resets to it so a channel
  // never sees a phantom press while coming out of reset.
  localparam logic [BTN_WIDTH-1:0] IDLE_PINS = {BTN_WIDTH{ACTIVE_LOW}};

  logic [BTN_WIDTH-1:0] sync1_q, sync1_d;
  logic [BTN_WIDTH-1:0] sync2_q, sync2_d;
  logic [BTN_WIDTH-1:0] s;
  logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic                 tick;

  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    s         = sync2_q ^ IDLE_PINS;
    tick      = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= IDLE_PINS;
      sync2_q   <= IDLE_PINS;
      pre_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_chan
    btn_debounce_repeat_chan #(
      .DB_TICKS  (DB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .REP_TICKS (REP_TICKS),
      .REP_EN    (REP_EN[i])
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .s          (s[i]),
      .btn_out    (btn_out[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_long   (btn_long[i]),
      .btn_rep    (btn_rep[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// tb/tb_btn_debounce_repeat.sv - self-checking bench for btn_debounce_repeat
module tb_btn_debounce_repeat;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int LT = 10;
  localparam int RT = 5;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  typedef struct packed {
    logic [3:0]  kind;
    logic [3:0]  chan;
    logic [23:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_in_al;
  logic [3:0] m_out, m_press, m_rel, m_long, m_rep;
  logic [3:0] a_out, a_press, a_rel, a_long, a_rep;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ecnt   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  always #5 clk = ~clk;

  btn_debounce_repeat #(
    .BTN_WIDTH(4), .TICK_DIV(TD), .DB_TICKS(DB), .LONG_TICKS(LT),
    .REP_TICKS(RT), .REP_EN(4'b0001), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_out(m_out),
    .btn_press(m_press), .btn_release(m_rel), .btn_long(m_long), .btn_rep(m_rep)
  );

  btn_debounce_repeat #(
    .BTN_WIDTH(4), .TICK_DIV(TD), .DB_TICKS(DB), .LONG_TICKS(LT),
    .REP_TICKS(RT), .REP_EN(4'b0001), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .rst(rst), .btn_in(btn_in_al), .btn_out(a_out),
    .btn_press(a_press), .btn_release(a_rel), .btn_long(a_long), .btn_rep(a_rep)
  );

  // Edge counter and clk edges since reset release (prescaler phase reference).
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  function automatic ev_t mk_ev(input int k, input int ch, input int c);
    ev_t e;
    e.kind = 4'(k);
    e.chan = 4'(ch);
    e.cyc  = 24'(c);
    return e;
  endfunction

  function automatic void expect_ev(input int k, input int ch, input int c);
    exp_q.push_back(mk_ev(k, ch, c));
  endfunction

  // Channels 0..3 are the active-high instance, 4..7 the active-low one.
  function automatic logic pulse_bit(input int k, input int ch);
    logic [7:0] v;
    case (k)
      K_PRESS: v = {a_press, m_press};
      K_REL:   v = {a_rel, m_rel};
      K_LONG:  v = {a_long, m_long};
      default: v = {a_rep, m_rep};
    endcase
    return v[3'(ch)];
  endfunction

  // Edge at which a pin level driven at the negedge after edge c becomes
  // btn_out: two sync edges, then DB ticks; ticks fall on edges whose
  // preceding phase count is TD-1.
  function automatic int accept_edge(input int c, input int e);
    int ph;
    int d;
    ph = (e + 2) % TD;
    d  = (TD - 1 - ph + TD) % TD;
    return c + 3 + d + (DB - 1) * TD;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        for (int ch = 0; ch < 8; ch++) begin
          if (pulse_bit(k, ch)) obs_q.push_back(mk_ev(k, ch, cyc));
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (m_out !== 4'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", m_out); end
    checks++;
    if (m_press !== 4'h0) begin errors++; $display("FAIL reset_press: got %h expected 0", m_press); end
    checks++;
    if (m_rel !== 4'h0) begin errors++; $display("FAIL reset_release: got %h expected 0", m_rel); end
    checks++;
    if (m_long !== 4'h0) begin errors++; $display("FAIL reset_long: got %h expected 0", m_long); end
    checks++;
    if (m_rep !== 4'h0) begin errors++; $display("FAIL reset_rep: got %h expected 0", m_rep); end
    checks++;
    if ({a_out, a_press, a_rel, a_long, a_rep} !== 20'h0) begin
      errors++;
      $display("FAIL reset_al: got %h expected 0", {a_out, a_press, a_rel, a_long, a_rep});
    end
    rst = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_bounce();
    int bad;
    int p;
    int r;
    ev_t e;
    ev_t o;
    bad = 0;
    for (int seg = 0; seg < 20; seg++) begin
      btn_in[0] = ~btn_in[0];
      repeat (5) begin
        @(negedge clk);
        if (m_out[0] !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bounce_level: got %0d high samples expected 0", bad); end
    btn_in[0] = 1'b1;
    p = accept_edge(cyc, ecnt);
    expect_ev(K_PRESS, 0, p);
    expect_ev(K_REP, 0, p);
    wait_cyc(p - 1);
    checks++;
    if (m_out[0] !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b expected 0", m_out[0]); end
    wait_cyc(p);
    checks++;
    if (m_out[0] !== 1'b1) begin errors++; $display("FAIL bounce_rise: got %b expected 1", m_out[0]); end
    wait_cyc(p + 8);
    btn_in[0] = 1'b0;
    r = accept_edge(cyc, ecnt);
    expect_ev(K_REL, 0, r);
    wait_cyc(r + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL bounce_ev: got none expected kind=%0d ch=%0d cyc=%0d", e.kind, e.chan, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL bounce_ev: got kind=%0d ch=%0d cyc=%0d expected kind=%0d ch=%0d cyc=%0d",
                   o.kind, o.chan, o.cyc, e.kind, e.chan, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_extra: got %0d extra events (first kind=%0d ch=%0d cyc=%0d) expected 0",
               obs_q.size(), obs_q[0].kind, obs_q[0].chan, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_hold(input int ch, input bit en);
    int p;
    int r;
    ev_t e;
    ev_t o;
    btn_in[ch] = 1'b1;
    p = accept_edge(cyc, ecnt);
    expect_ev(K_PRESS, ch, p);
    expect_ev(K_REP, ch, p);
    expect_ev(K_LONG, ch, p + LT * TD);
    if (en) begin
      expect_ev(K_REP, ch, p + LT * TD);
      for (int k = 1; k <= 6; k++) expect_ev(K_REP, ch, p + LT * TD + k * RT * TD);
    end
    wait_cyc(p + 100);
    checks++;
    if (m_out[ch] !== 1'b1) begin errors++; $display("FAIL hold_level ch%0d: got %b expected 1", ch, m_out[ch]); end
    wait_cyc(p + 150);
    btn_in[ch] = 1'b0;
    r = accept_edge(cyc, ecnt);
    expect_ev(K_REL, ch, r);
    wait_cyc(r + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL hold_ev ch%0d: got none expected kind=%0d ch=%0d cyc=%0d", ch, e.kind, e.chan, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL hold_ev ch%0d: got kind=%0d ch=%0d cyc=%0d expected kind=%0d ch=%0d cyc=%0d",
                   ch, o.kind, o.chan, o.cyc, e.kind, e.chan, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL hold_extra ch%0d: got %0d extra events (first kind=%0d ch=%0d cyc=%0d) expected 0",
               ch, obs_q.size(), obs_q[0].kind, obs_q[0].chan, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_release_vs_repeat();
    int p;
    int r;
    ev_t e;
    ev_t o;
    btn_in[0] = 1'b1;
    p = accept_edge(cyc, ecnt);
    expect_ev(K_PRESS, 0, p);
    expect_ev(K_REP, 0, p);
    expect_ev(K_LONG, 0, p + LT * TD);
    expect_ev(K_REP, 0, p + LT * TD);
    // Released so acceptance lands on the first repeat threshold (p+60).
    wait_cyc(p + 48);
    btn_in[0] = 1'b0;
    r = accept_edge(cyc, ecnt);
    expect_ev(K_REL, 0, r);
    wait_cyc(r + 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL collide_ev: got none expected kind=%0d ch=%0d cyc=%0d", e.kind, e.chan, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL collide_ev: got kind=%0d ch=%0d cyc=%0d expected kind=%0d ch=%0d cyc=%0d",
                   o.kind, o.chan, o.cyc, e.kind, e.chan, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL collide_extra: got %0d extra events (first kind=%0d ch=%0d cyc=%0d) expected 0",
               obs_q.size(), obs_q[0].kind, obs_q[0].chan, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_active_low();
    int p;
    int r;
    ev_t e;
    ev_t o;
    repeat (20) @(negedge clk);
    checks++;
    if (a_out !== 4'h0) begin errors++; $display("FAIL al_idle: got %h expected 0", a_out); end
    btn_in_al = 4'hE;
    p = accept_edge(cyc, ecnt);
    expect_ev(K_PRESS, 4, p);
    expect_ev(K_REP, 4, p);
    wait_cyc(p);
    checks++;
    if (a_out !== 4'h1) begin errors++; $display("FAIL al_press: got %h expected 1", a_out); end
    wait_cyc(p + 8);
    btn_in_al = 4'hF;
    r = accept_edge(cyc, ecnt);
    expect_ev(K_REL, 4, r);
    wait_cyc(r + 4);
    checks++;
    if (a_out !== 4'h0) begin errors++; $display("FAIL al_release: got %h expected 0", a_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL al_ev: got none expected kind=%0d ch=%0d cyc=%0d", e.kind, e.chan, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL al_ev: got kind=%0d ch=%0d cyc=%0d expected kind=%0d ch=%0d cyc=%0d",
                   o.kind, o.chan, o.cyc, e.kind, e.chan, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL al_extra: got %0d extra events (first kind=%0d ch=%0d cyc=%0d) expected 0",
               obs_q.size(), obs_q[0].kind, obs_q[0].chan, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int p;
    int p2;
    int r;
    ev_t e;
    ev_t o;
    btn_in[0] = 1'b1;
    p = accept_edge(cyc, ecnt);
    expect_ev(K_PRESS, 0, p);
    expect_ev(K_REP, 0, p);
    expect_ev(K_LONG, 0, p + LT * TD);
    expect_ev(K_REP, 0, p + LT * TD);
    wait_cyc(p + 50);
    btn_in = 4'b1101;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({m_out, m_press, m_rel, m_long, m_rep} !== 20'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", {m_out, m_press, m_rel, m_long, m_rep});
    end
    @(negedge clk);
    rst = 1'b1;
    p2 = accept_edge(cyc, ecnt);
    expect_ev(K_PRESS, 0, p2);
    expect_ev(K_PRESS, 2, p2);
    expect_ev(K_PRESS, 3, p2);
    expect_ev(K_REP, 0, p2);
    expect_ev(K_REP, 2, p2);
    expect_ev(K_REP, 3, p2);
    wait_cyc(p2);
    checks++;
    if (m_out !== 4'b1101) begin errors++; $display("FAIL midreset_repress: got %h expected d", m_out); end
    wait_cyc(p2 + 8);
    btn_in = 4'b0000;
    r = accept_edge(cyc, ecnt);
    expect_ev(K_REL, 0, r);
    expect_ev(K_REL, 2, r);
    expect_ev(K_REL, 3, r);
    wait_cyc(r + 4);
    checks++;
    if (m_out !== 4'h0) begin errors++; $display("FAIL midreset_release: got %h expected 0", m_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL midreset_ev: got none expected kind=%0d ch=%0d cyc=%0d", e.kind, e.chan, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL midreset_ev: got kind=%0d ch=%0d cyc=%0d expected kind=%0d ch=%0d cyc=%0d",
                   o.kind, o.chan, o.cyc, e.kind, e.chan, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_extra: got %0d extra events (first kind=%0d ch=%0d cyc=%0d) expected 0",
               obs_q.size(), obs_q[0].kind, obs_q[0].chan, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_in    = 4'h0;
    btn_in_al = 4'hF;
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_bounce();
    test_hold(0, 1'b1);
    test_hold(1, 1'b0);
    test_release_vs_repeat();
    test_active_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
